step_pulse_generator: RTL and testbench

//  Stimulus source for the activity-tracking datapath. Emits single-cycle step pulses
//  at a selectable rate (walk / jog / run / hybrid schedule) on the X line that the

---
 rtl/step_pulse_generator_if.sv | 21 ++
 rtl/step_pulse_generator.sv | 231 +++++++++++++++++++++++
 tb/tb_step_pulse_generator.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_pulse_generator_if.sv
// Control and status bundle between the step-pulse generator and its consumer.
// The master drives enable/mode; the slave (the generator) returns the pulse
// stream and the shared one-second time base.
interface step_pulse_generator_if;
    logic       en;
    logic [1:0] mode;
    logic       pulse;
    logic       sec_tick;
    logic [7:0] sec_count;
    logic [7:0] cur_rate;

    modport master (
        output en, mode,
        input  pulse, sec_tick, sec_count, cur_rate
    );

    modport slave (
        input  en, mode,
        output pulse, sec_tick, sec_count, cur_rate
    );
endinterface

// File: rtl/step_pulse_generator.sv
// Step-pulse stimulus source: emits `rate` evenly spaced single-cycle pulses per
// second (walk / jog / run / hybrid schedule) plus a 1 s tick and seconds count.
// The per-second pulse interval floor(CLK_HZ/rate) comes from one shared
// restoring divider: a 32-cycle pre-roll computes the first second, after which
// the divider works on the following second during cycles 0..CW of each second.
module step_pulse_generator #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int WALK_SPS = 32,
    parameter int JOG_SPS  = 64,
    parameter int RUN_SPS  = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    step_pulse_generator_if.slave  bus
);
    // Counter width must hold CLK_HZ itself, since it is also the dividend.
    localparam int            CW        = $clog2(CLK_HZ + 1);
    localparam int            PRE_CYC   = 32;
    localparam logic [CW-1:0] LAST_CYC  = CW'(CLK_HZ - 1);
    localparam logic [CW-1:0] DIVIDEND  = CW'(CLK_HZ);
    localparam logic [5:0]    DIV_STEPS = 6'(CW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_mode;
    logic [4:0]    r_pre;
    logic [CW-1:0] r_cyc;
    logic [CW-1:0] r_step;
    logic [7:0]    r_pcnt;
    logic [7:0]    r_sec;
    logic [7:0]    r_rate;
    logic [CW-1:0] r_ival;
    logic          r_pulse;
    logic          r_tick;

    logic [4:0]    w_pre_nxt;
    logic [CW-1:0] w_cyc_nxt;
    logic [CW-1:0] w_step_nxt;
    logic [7:0]    w_pcnt_nxt;
    logic [7:0]    w_sec_nxt;
    logic [7:0]    w_rate_nxt;
    logic [CW-1:0] w_ival_nxt;
    logic          w_pulse_nxt;
    logic          w_tick_nxt;
    logic          w_mode_chg;

    // Divider: r_div_q ends up holding the quotient, r_div_d doubles as the
    // buffered rate for the second whose interval is being computed.
    logic [CW-1:0] r_div_q;
    logic [7:0]    r_div_r;
    logic [7:0]    r_div_d;
    logic [5:0]    r_div_cnt;
    logic          w_div_start;
    logic [7:0]    w_div_rate;
    logic [8:0]    w_div_sh;
    logic          w_div_ge;
    logic [7:0]    w_div_sub;

    // Steps/s for a mode and 1-based second index; hybrid follows its fixed schedule.
    function automatic logic [7:0] f_rate(input logic [1:0] m, input logic [9:0] s);
        logic [7:0] v;
        v = '0;
        case (m)
            2'b00:   v = 8'(WALK_SPS);
            2'b01:   v = 8'(JOG_SPS);
            2'b10:   v = 8'(RUN_SPS);
            default: begin
                case (s)
                    10'd1:   v = 8'd20;
                    10'd2:   v = 8'd33;
                    10'd3:   v = 8'd66;
                    10'd4:   v = 8'd27;
                    10'd5:   v = 8'd70;
                    10'd6:   v = 8'd30;
                    10'd7:   v = 8'd19;
                    10'd8:   v = 8'd30;
                    10'd9:   v = 8'd33;
                    default: begin
                        if (s <= 10'd73)       v = 8'd69;
                        else if (s <= 10'd79)  v = 8'd34;
                        else if (s <= 10'd144) v = 8'd124;
                        else                   v = 8'd0;
                    end
                endcase
            end
        endcase
        return v;
    endfunction

    // A mode change only restarts an active generator; idle just tracks the input.
    assign w_mode_chg = bus.en && (r_state != S_IDLE) && (bus.mode != r_mode);

    // Next-state and next-counter logic; outputs are derived from the next values
    // so the registered pulse/tick line up with the cycle counter they describe.
    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        w_cyc_nxt   = r_cyc;
        w_step_nxt  = r_step;
        w_pcnt_nxt  = r_pcnt;
        w_sec_nxt   = r_sec;
        w_rate_nxt  = r_rate;
        w_ival_nxt  = r_ival;
        w_div_start = 1'b0;
        w_div_rate  = '0;

        if (!bus.en) begin
            w_state_nxt = S_IDLE;
            w_pre_nxt   = '0;
            w_cyc_nxt   = '0;
            w_step_nxt  = '0;
            w_pcnt_nxt  = '0;
            w_sec_nxt   = '0;
            w_rate_nxt  = '0;
            w_ival_nxt  = '0;
        end else if (r_state == S_IDLE || w_mode_chg) begin
            // Start or restart: pre-roll computes the first second's interval.
            w_state_nxt = S_PRE;
            w_pre_nxt   = '0;
            w_cyc_nxt   = '0;
            w_step_nxt  = '0;
            w_pcnt_nxt  = '0;
            w_sec_nxt   = '0;
            w_rate_nxt  = '0;
            w_ival_nxt  = '0;
            w_div_start = 1'b1;
            w_div_rate  = f_rate(bus.mode, 10'd1);
        end else if (r_state == S_PRE) begin
            if (r_pre == 5'(PRE_CYC - 1)) begin
                w_state_nxt = S_RUN;
                w_pre_nxt   = '0;
                w_rate_nxt  = r_div_d;
                w_ival_nxt  = r_div_q;
            end else begin
                w_pre_nxt = r_pre + 5'd1;
            end
        end else begin
            if (r_cyc == LAST_CYC) begin
                // Second boundary: swap in the interval computed during this second.
                w_cyc_nxt  = '0;
                w_step_nxt = '0;
                w_pcnt_nxt = '0;
                w_sec_nxt  = (r_sec == 8'hFF) ? r_sec : r_sec + 8'd1;
                w_rate_nxt = r_div_d;
                w_ival_nxt = r_div_q;
            end else begin
                w_cyc_nxt  = r_cyc + CW'(1);
                w_step_nxt = (r_step == r_ival - CW'(1)) ? '0 : r_step + CW'(1);
                w_pcnt_nxt = r_pcnt + {7'd0, r_pulse};
                if (r_cyc == '0) begin
                    w_div_start = 1'b1;
                    w_div_rate  = f_rate(r_mode, {2'b00, r_sec} + 10'd2);
                end
            end
        end

        w_pulse_nxt = (w_state_nxt == S_RUN) && (w_step_nxt == w_ival_nxt - CW'(1)) &&
                      (w_pcnt_nxt < w_rate_nxt);
        w_tick_nxt  = (w_state_nxt == S_RUN) && (w_cyc_nxt == LAST_CYC);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mode  <= 2'b00;
            r_pre   <= '0;
            r_cyc   <= '0;
            r_step  <= '0;
            r_pcnt  <= '0;
            r_sec   <= '0;
            r_rate  <= '0;
            r_ival  <= '0;
            r_pulse <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= bus.mode;
            r_pre   <= w_pre_nxt;
            r_cyc   <= w_cyc_nxt;
            r_step  <= w_step_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_sec   <= w_sec_nxt;
            r_rate  <= w_rate_nxt;
            r_ival  <= w_ival_nxt;
            r_pulse <= w_pulse_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // When it fits the difference is below the divisor, so 8-bit math is exact.
    assign w_div_sh  = {r_div_r, r_div_q[CW-1]};
    assign w_div_ge  = (w_div_sh >= {1'b0, r_div_d});
    assign w_div_sub = w_div_sh[7:0] - r_div_d;

    // Shared divider: CW steps per computation, loaded on each start request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_q   <= '0;
            r_div_r   <= '0;
            r_div_d   <= '0;
            r_div_cnt <= '0;
        end else if (!bus.en) begin
            r_div_q   <= '0;
            r_div_r   <= '0;
            r_div_d   <= '0;
            r_div_cnt <= '0;
        end else if (w_div_start) begin
            r_div_q   <= DIVIDEND;
            r_div_r   <= '0;
            r_div_d   <= w_div_rate;
            r_div_cnt <= DIV_STEPS;
        end else if (r_div_cnt != '0) begin
            r_div_q   <= {r_div_q[CW-2:0], w_div_ge};
            r_div_r   <= w_div_ge ? w_div_sub : w_div_sh[7:0];
            r_div_cnt <= r_div_cnt - 6'd1;
        end
    end

    assign bus.pulse     = r_pulse;
    assign bus.sec_tick  = r_tick;
    assign bus.sec_count = r_sec;
    assign bus.cur_rate  = r_rate;
endmodule

// File: tb/tb_step_pulse_generator.sv
// Bench for step_pulse_generator. Instance A (1000 Hz) runs the directed
// walk/jog/run/restart/reset/enable sequence; instance B (248 Hz) runs the
// hybrid schedule long enough to reach sec_count saturation. Stimulus pushes the
// expected per-second result; the monitor pops one entry per sec_tick.
module tb_step_pulse_generator;
    localparam int HZ_A = 1000;
    localparam int HZ_B = 248;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    step_pulse_generator_if ifa ();
    step_pulse_generator_if ifb ();

    step_pulse_generator #(.CLK_HZ(HZ_A)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa)
    );

    step_pulse_generator #(.CLK_HZ(HZ_B)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb)
    );

    typedef struct {
        int rate;
        int ival;
        int tail;
        int sc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   flush_a = 0;
    int   flush_b = 0;

    int m_now;
    int m_n[2];
    int m_last[2];
    int m_gmin[2];
    int m_gmax[2];
    int m_seen[2];

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t mkx(input int rate, input int ival, input int tail, input int sc);
        exp_t e;
        e.rate = rate;
        e.ival = ival;
        e.tail = tail;
        e.sc   = sc;
        return e;
    endfunction

    function automatic int hyb(input int s);
        case (s)
            1: return 20;
            2: return 33;
            3: return 66;
            4: return 27;
            5: return 70;
            6: return 30;
            7: return 19;
            8: return 30;
            9: return 33;
            default: ;
        endcase
        if (s <= 73)  return 69;
        if (s <= 79)  return 34;
        if (s <= 144) return 124;
        return 0;
    endfunction

    function automatic exp_t mk_hyb(input int hz, input int s);
        int r;
        int iv;
        r  = hyb(s);
        iv = (r > 0) ? hz / r : 0;
        return mkx(r, iv, hz - r * iv, (s - 1 > 255) ? 255 : s - 1);
    endfunction

    task automatic clear_acc(input int d);
        m_n[d]    = 0;
        m_last[d] = -1;
        m_gmin[d] = 1 << 30;
        m_gmax[d] = 0;
    endtask

    // Monitor: accumulate pulses per second, compare against the queue on each tick.
    initial begin : monitor
        exp_t  e;
        logic  p;
        logic  t;
        int    sc;
        int    cr;
        int    fl;
        int    gap;
        bit    have;
        string nm;
        m_now = 0;
        for (int d = 0; d < 2; d++) begin
            m_seen[d] = 0;
            clear_acc(d);
        end
        forever begin
            @(negedge clk);
            m_now++;
            for (int d = 0; d < 2; d++) begin
                if (d == 0) begin
                    p = ifa.pulse; t = ifa.sec_tick; sc = ifa.sec_count; cr = ifa.cur_rate;
                    fl = flush_a; nm = "A"; have = (qa.size() > 0);
                end else begin
                    p = ifb.pulse; t = ifb.sec_tick; sc = ifb.sec_count; cr = ifb.cur_rate;
                    fl = flush_b; nm = "B"; have = (qb.size() > 0);
                end
                if (fl != m_seen[d]) begin
                    m_seen[d] = fl;
                    clear_acc(d);
                end
                if (p) begin
                    if (m_last[d] >= 0) begin
                        gap = m_now - m_last[d];
                        if (gap < m_gmin[d]) m_gmin[d] = gap;
                        if (gap > m_gmax[d]) m_gmax[d] = gap;
                    end
                    m_n[d]++;
                    m_last[d] = m_now;
                end
                if (t) begin
                    if (!have) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL %s_tick: got unexpected sec_tick at cycle %0d, expected none", nm, m_now);
                    end else begin
                        if (d == 0) e = qa.pop_front();
                        else        e = qb.pop_front();
                        check({nm, "_pulse_count"}, m_n[d], e.rate);
                        if (e.rate > 1) begin
                            check({nm, "_gap_min"}, m_gmin[d], e.ival);
                            check({nm, "_gap_max"}, m_gmax[d], e.ival);
                        end
                        if (e.rate > 0) check({nm, "_tail"}, m_now - m_last[d], e.tail);
                        check({nm, "_sec_count_at_tick"}, sc, e.sc);
                        check({nm, "_cur_rate_at_tick"}, cr, e.rate);
                    end
                    clear_acc(d);
                end
            end
        end
    end

    task automatic wait_tick_a(input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2 * HZ_A + 100 && !hit; i++) begin
            @(negedge clk);
            if (ifa.sec_tick) hit = 1'b1;
        end
        if (!hit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no sec_tick, expected one within %0d cycles", nm, 2 * HZ_A + 100);
        end
    endtask

    task automatic stim_a();
        // Walk: I=31, last pulse at 991, tail 8.
        ifa.mode = 2'b00;
        ifa.en   = 1'b1;
        qa.push_back(mkx(32, 31, 8, 0));
        wait_tick_a("walk_s1");
        @(posedge clk); #1;
        check("A_walk_sec_count", ifa.sec_count, 1);
        check("A_walk_cur_rate", ifa.cur_rate, 32);

        // Switch to jog at cycle 500 of second 2.
        repeat (500) @(posedge clk);
        #1;
        ifa.mode = 2'b01;
        flush_a++;
        check("A_chg_pulse", ifa.pulse, 0);
        @(posedge clk); #1;
        check("A_chg_sec_count", ifa.sec_count, 0);
        check("A_chg_cur_rate", ifa.cur_rate, 0);
        qa.push_back(mkx(64, 15, 40, 0));
        qa.push_back(mkx(64, 15, 40, 1));
        wait_tick_a("jog_s1");
        wait_tick_a("jog_s2");
        @(posedge clk); #1;
        check("A_jog_sec_count", ifa.sec_count, 2);
        check("A_jog_cur_rate", ifa.cur_rate, 64);

        // Run for 3 s: I=7, last pulse at 895, tail 104.
        ifa.mode = 2'b10;
        flush_a++;
        for (int s = 0; s < 3; s++) qa.push_back(mkx(128, 7, 104, s));
        for (int s = 0; s < 3; s++) wait_tick_a("run_s");
        @(posedge clk); #1;
        check("A_run_sec_count", ifa.sec_count, 3);
        check("A_run_cur_rate", ifa.cur_rate, 128);

        // Reset mid-second at cycle 405, which carries pulse k=58.
        repeat (405) @(posedge clk);
        #1;
        check("A_pulse_at_405", ifa.pulse, 1);
        rst_a = 1'b1;
        flush_a++;
        #1;
        check("A_rst_pulse", ifa.pulse, 0);
        check("A_rst_sec_tick", ifa.sec_tick, 0);
        check("A_rst_sec_count", ifa.sec_count, 0);
        check("A_rst_cur_rate", ifa.cur_rate, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        qa.push_back(mkx(128, 7, 104, 0));
        wait_tick_a("rst_restart");
        @(posedge clk); #1;
        check("A_restart_sec_count", ifa.sec_count, 1);

        // Drop enable for 10 cycles, then restart in hybrid mode.
        repeat (302) @(posedge clk);
        #1;
        ifa.en = 1'b0;
        flush_a++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("A_off_pulse", ifa.pulse, 0);
            check("A_off_sec_count", ifa.sec_count, 0);
        end
        ifa.mode = 2'b11;
        ifa.en   = 1'b1;
        qa.push_back(mkx(20, 50, 0, 0));
        wait_tick_a("hyb_s1");
        @(posedge clk); #1;
        check("A_hyb_sec_count", ifa.sec_count, 1);
        check("A_hyb_s2_cur_rate", ifa.cur_rate, 33);
        ifa.en = 1'b0;
    endtask

    task automatic stim_b();
        bit done;
        ifb.mode = 2'b11;
        ifb.en   = 1'b1;
        for (int s = 1; s <= 257; s++) qb.push_back(mk_hyb(HZ_B, s));
        done = 1'b0;
        for (int i = 0; i < 260 * HZ_B && !done; i++) begin
            @(negedge clk);
            if (qb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL B_timeout: got %0d seconds pending, expected 0", qb.size());
        end
        @(posedge clk); #1;
        check("B_sec_count_sat", ifb.sec_count, 255);
        check("B_cur_rate_late", ifb.cur_rate, 0);
        ifb.en = 1'b0;
    endtask

    initial begin
        rst_a    = 1'b1;
        rst_b    = 1'b1;
        ifa.en   = 1'b0;
        ifa.mode = 2'b00;
        ifb.en   = 1'b0;
        ifb.mode = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("A_reset_pulse", ifa.pulse, 0);
        check("A_reset_sec_tick", ifa.sec_tick, 0);
        check("A_reset_sec_count", ifa.sec_count, 0);
        check("A_reset_cur_rate", ifa.cur_rate, 0);
        check("B_reset_sec_count", ifb.sec_count, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk); #1;
        fork
            stim_a();
            stim_b();
        join
        repeat (2) @(posedge clk);
        check("A_queue_left", qa.size(), 0);
        check("B_queue_left", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
